memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: the CPU core (instruction fetch and data loads/stores) and a DMA/debug master.
- Core has fixed priority, bounded by a starvation limit so DMA is not locked out.
- Performs alignment checking and enforces a bus timeout, returning an error instead of hanging.
- Sits between the core's pad interface logic and the memory/peripheral fabric; core_wait feeds the phase generator as a stall.

Parameters:
- MAX_CORE_BURST, 4, consecutive core grants allowed while DMA is waiting before DMA is forced a grant (>=1).
- TIMEOUT_CYCLES, 64, mem_valid cycles without mem_ready before abort; 0 disables timeout.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- core_req  in  1  core request, held until core_ack
- core_write  in  1  1=store, 0=load
- core_size  in  2  00 byte, 01 half, 11 word; 10 illegal
- core_addr  in  32  byte address
- core_wdata  in  32  store data, right-aligned
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  32  load data, valid with core_ack
- core_error  out  1  valid with core_ack; misaligned/illegal/timeout
- core_wait  out  1  core_req & ~core_ack; stall to phase generator
- dma_req, dma_write, dma_size, dma_addr, dma_wdata  in  1/1/2/32/32  same rules as core_*
- dma_ack, dma_rdata, dma_error  out  1/32/1  same rules as core_*
- mem_valid  out  1  bus request
- mem_write  out  1  registered copy of granted write
- mem_size  out  2  registered copy of granted size
- mem_addr  out  32  registered copy of granted address
- mem_wdata  out  32  registered copy of granted wdata
- mem_ready  in  1  transfer done this cycle
- mem_rdata  in  32  load data, valid with mem_ready

Behaviour:
- Clock and reset: one clock, port clock; synchronous active-high reset, port reset.
- Reset values: all outputs 0; state IDLE; burst and timeout counters 0. A reset mid-transfer abandons it: mem_valid drops next edge and no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests.
  - Grant DMA if dma_req & (~core_req | burst_cnt==MAX_CORE_BURST); otherwise grant core if core_req.
  - On grant, latch the requester's fields into the mem_* registers.
- Grant to a legal access: next state BUSY, mem_valid=1 from the next cycle.
- Grant to an illegal access: word with addr[1:0]!=0, half with addr[0]!=0, or size 10.
  - Next state RESP, error=1, rdata=0, no mem_valid cycle.
- BUSY:
  - mem_valid held high; mem_* fields stable.
  - On mem_ready, capture mem_rdata (loads; 0 for stores), go to RESP with error=0, mem_valid low next cycle.
  - When timeout_cnt reaches TIMEOUT_CYCLES-1 without mem_ready: go to RESP, error=1, rdata=0.
  - If mem_ready and timeout coincide, mem_ready wins.
- RESP:
  - Granted requester's ack=1 for exactly this cycle, with rdata and error.
  - No sampling; next state IDLE.
  - The requester must drop or replace req at the edge ending RESP.
- Latency:
  - Legal access with zero-wait memory: req seen in IDLE at cycle 0, mem_valid at cycle 1, mem_ready at cycle 1, ack at cycle 2.
  - Back-to-back: next grant at cycle 3.
  - Illegal access: ack at cycle 1.
- burst_cnt:
  - Increments on a core grant while dma_req=1, saturating at MAX_CORE_BURST.
  - Clears on a DMA grant, or on a core grant with dma_req=0.
- timeout_cnt: clears on entry to BUSY; increments each BUSY cycle without mem_ready.
- Ack of the non-granted requester stays 0; its rdata/error outputs keep their last values.
- Requests dropped before ack are a protocol violation; the behaviour is undefined and covered by an assertion only.

Decomposition:
- Package bus_pkg holds:
  - state enum (IDLE/BUSY/RESP);
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11 (matching the core's pad_data_size encoding);
  - packed struct bus_request_t {write, size, addr, wdata}.
- One sub-module: bus_align_check, combinational, takes bus_request_t and outputs illegal. It is instantiated once on the selected request.

Test Plan:
- Core-only load: core_req, word, addr 0x100; mem_ready at cycle 1 with rdata 0xDEADBEEF -> core_ack at cycle 2, core_rdata=0xDEADBEEF, core_error=0, core_wait high in cycles 0-1.
- Contention: core_req and dma_req held continuously, MAX_CORE_BURST=4, zero-wait memory -> grant order core×4, DMA, core×4, DMA; mem_addr alternates accordingly.
- Misaligned: dma_req, word write, addr 0x102 -> dma_ack at cycle 1 with dma_error=1, mem_valid never asserted; same for half at 0x101 and size 10.
- Timeout: TIMEOUT_CYCLES=8, mem_ready held 0 -> mem_valid high exactly 8 cycles, then core_ack with core_error=1, core_rdata=0; state returns to IDLE.
- Wait states: mem_ready after 5 cycles, core store 0x55 byte at 0x203 -> mem_* fields constant all 5 cycles, mem_write=1, mem_size=00, ack one cycle after mem_ready.
- Reset mid-BUSY: assert reset in cycle 3 of a transfer -> next edge: mem_valid=0, all acks 0, counters 0; a new core_req after reset is granted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, transfer size codes
// and the request bundle carried from a requester to the memory bus.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Same encoding as the core's pad_data_size; 2'b10 is illegal.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_request_t;

endpackage

// File: rtl/bus_align_check.sv
// Flags a request that cannot go on the bus: misaligned half/word or the
// reserved size code.
module bus_align_check
    import bus_pkg::*;
(
    input  bus_request_t req,
    output logic         illegal
);

    // Only size and the low address bits matter here.
    logic unused_bits;
    assign unused_bits = ^{req.write, req.wdata, req.addr[31:2]};

    always_comb begin
        illegal = 1'b0;
        case (req.size)
            SIZE_BYTE: illegal = 1'b0;
            SIZE_HALF: illegal = req.addr[0];
            SIZE_WORD: illegal = (req.addr[1:0] != 2'b00);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter for the external memory bus: core has priority, DMA is
// forced in after MAX_CORE_BURST core grants, stuck transfers abort with error.
module memory_bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_CORE_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [1:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ack,
    output logic [31:0] core_rdata,
    output logic        core_error,
    output logic        core_wait,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [1:0]  dma_size,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_error,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int BW = $clog2(MAX_CORE_BURST + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t       state_reg, state_next;
    bus_request_t core_request, dma_request, sel_request, mem_request_reg;
    logic         grant_dma, grant_core, grant_any, illegal, timed_out;
    logic         owner_dma_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic [TW-1:0] timeout_cnt_reg;
    logic         resp_start, resp_dma, resp_error;
    logic [31:0]  resp_rdata;
    logic [31:0]  core_rdata_reg, dma_rdata_reg;
    logic         core_error_reg, dma_error_reg;

    assign core_request = '{write: core_write, size: core_size, addr: core_addr, wdata: core_wdata};
    assign dma_request  = '{write: dma_write, size: dma_size, addr: dma_addr, wdata: dma_wdata};

    assign grant_dma   = dma_req & (~core_req | (burst_cnt_reg == BW'(MAX_CORE_BURST)));
    assign grant_core  = core_req & ~grant_dma;
    assign grant_any   = grant_dma | grant_core;
    assign sel_request = grant_dma ? dma_request : core_request;
    assign timed_out   = (TIMEOUT_CYCLES != 0) && (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    bus_align_check u_align (
        .req     (sel_request),
        .illegal (illegal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = illegal ? RESP : BUSY;
            BUSY:    if (mem_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = (state_reg == BUSY);
        core_ack  = (state_reg == RESP) && !owner_dma_reg;
        dma_ack   = (state_reg == RESP) && owner_dma_reg;
        core_wait = core_req & ~core_ack;
    end

    // Result is written into the owner's registers on entry to RESP, so the
    // other requester's rdata/error keep their previous values.
    assign resp_start = (state_next == RESP) && (state_reg != RESP);
    assign resp_dma   = (state_reg == IDLE) ? grant_dma : owner_dma_reg;
    assign resp_error = !((state_reg == BUSY) && mem_ready);
    assign resp_rdata = ((state_reg == BUSY) && mem_ready && !mem_request_reg.write) ? mem_rdata : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_request_reg <= '0;
            owner_dma_reg   <= 1'b0;
            burst_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            core_rdata_reg  <= 32'd0;
            core_error_reg  <= 1'b0;
            dma_rdata_reg   <= 32'd0;
            dma_error_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && grant_any) begin
                mem_request_reg <= sel_request;
                owner_dma_reg   <= grant_dma;
                timeout_cnt_reg <= '0;
                if (grant_core && dma_req) begin
                    if (burst_cnt_reg != BW'(MAX_CORE_BURST))
                        burst_cnt_reg <= burst_cnt_reg + BW'(1);
                end else begin
                    burst_cnt_reg <= '0;
                end
            end
            if (state_reg == BUSY && !mem_ready && !timed_out)
                timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
            if (resp_start) begin
                if (resp_dma) begin
                    dma_rdata_reg <= resp_rdata;
                    dma_error_reg <= resp_error;
                end else begin
                    core_rdata_reg <= resp_rdata;
                    core_error_reg <= resp_error;
                end
            end
        end
    end

    assign mem_write  = mem_request_reg.write;
    assign mem_size   = mem_request_reg.size;
    assign mem_addr   = mem_request_reg.addr;
    assign mem_wdata  = mem_request_reg.wdata;
    assign core_rdata = core_rdata_reg;
    assign core_error = core_error_reg;
    assign dma_rdata  = dma_rdata_reg;
    assign dma_error  = dma_error_reg;

    // The granted requester must keep its request up until the ack.
    req_held_until_ack: assert property (@(posedge clock) disable iff (reset)
        (state_reg != IDLE) |-> (owner_dma_reg ? dma_req : core_req));

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and responses, bus-side
// and ack-side monitors pop and compare as the DUT presents them.
module tb_memory_bus_arbiter;
    import bus_pkg::*;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 0, core_write = 0, dma_req = 0, dma_write = 0;
    logic [1:0]  core_size = 0, dma_size = 0;
    logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic        core_ack, core_error, core_wait, dma_ack, dma_error;
    logic [31:0] core_rdata, dma_rdata;
    logic        mem_valid, mem_write, mem_ready;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    memory_bus_arbiter #(.MAX_CORE_BURST(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_write(core_write), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
        .core_rdata(core_rdata), .core_error(core_error), .core_wait(core_wait),
        .dma_req(dma_req), .dma_write(dma_write), .dma_size(dma_size),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .dma_error(dma_error),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        dma;
        logic [31:0] rdata;
        logic        error;
    } resp_t;

    bus_request_t exp_grant_q[$];
    resp_t        exp_resp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           lat = 0;
    logic [31:0]  rd_val = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model plus grant scoreboard: lat = mem_valid cycles before ready, -1 = never.
    initial begin
        int           vcnt;
        bus_request_t cur, snap;
        vcnt = 0;
        snap = '0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            if (mem_valid === 1'b1) begin
                cur = '{write: mem_write, size: mem_size, addr: mem_addr, wdata: mem_wdata};
                if (vcnt == 0) begin
                    if (exp_grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant: got unexpected bus request addr %0h, required none", mem_addr);
                    end else begin
                        check("grant", cur, exp_grant_q.pop_front());
                    end
                    snap = cur;
                end else begin
                    check("mem_stable", cur, snap);
                end
                mem_ready = (lat >= 0) && (vcnt == lat);
                mem_rdata = rd_val ^ mem_addr;
                vcnt++;
            end else begin
                mem_ready = 1'b0;
                vcnt = 0;
            end
        end
    end

    // Response scoreboard.
    initial begin
        resp_t act;
        forever begin
            @(negedge clock);
            if (core_ack === 1'b1 || dma_ack === 1'b1) begin
                check("ack_onehot", {core_ack, dma_ack}, 2'b01 & {1'b0, dma_ack} | 2'b10 & {core_ack, 1'b0} & {~dma_ack, 1'b0});
                act = '{dma: dma_ack, rdata: dma_ack ? dma_rdata : core_rdata,
                        error: dma_ack ? dma_error : core_error};
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp: got unexpected ack %0h, required none", act);
                end else begin
                    check("resp", act, exp_resp_q.pop_front());
                end
            end
        end
    end

    // One transfer from one requester; ill = hand-marked illegal access.
    task automatic txn(input logic is_dma, input logic wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int l, input logic ill);
        int   exp_cyc, exp_vc, ack_cyc, vc;
        logic exp_err;
        logic [31:0] exp_rd;
        lat = l;
        if (ill) begin
            exp_cyc = 1; exp_vc = 0; exp_err = 1'b1; exp_rd = 32'd0;
        end else if (l < 0) begin
            exp_cyc = TMO + 1; exp_vc = TMO; exp_err = 1'b1; exp_rd = 32'd0;
        end else begin
            exp_cyc = l + 2; exp_vc = l + 1; exp_err = 1'b0;
            exp_rd = wr ? 32'd0 : (rd_val ^ addr);
        end
        if (!ill) exp_grant_q.push_back('{write: wr, size: sz, addr: addr, wdata: wd});
        exp_resp_q.push_back('{dma: is_dma, rdata: exp_rd, error: exp_err});
        @(posedge clock); #1;
        if (is_dma) begin
            dma_req = 1; dma_write = wr; dma_size = sz; dma_addr = addr; dma_wdata = wd;
        end else begin
            core_req = 1; core_write = wr; core_size = sz; core_addr = addr; core_wdata = wd;
        end
        ack_cyc = -1;
        vc = 0;
        for (int c = 0; c < 200 && ack_cyc < 0; c++) begin
            @(negedge clock);
            if (mem_valid === 1'b1) vc++;
            if (!is_dma && c == 0) check("core_wait_c0", core_wait, 1'b1);
            if ((is_dma ? dma_ack : core_ack) === 1'b1) begin
                ack_cyc = c;
                if (!is_dma) check("core_wait_ack", core_wait, 1'b0);
            end
        end
        check("ack_cycle", ack_cyc, exp_cyc);
        check("mem_valid_cycles", vc, exp_vc);
        $display("txn %s wr=%0d size=%0b addr=%08h ack_cycle=%0d valid_cycles=%0d",
                 is_dma ? "dma " : "core", wr, sz, addr, ack_cyc, vc);
        @(posedge clock); #1;
        core_req = 0;
        dma_req = 0;
    endtask

    initial begin
        int acks, last_ack;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_acks", {core_ack, dma_ack}, 2'b00);
        check("rst_mem_fields", {mem_write, mem_size, mem_addr, mem_wdata}, 67'd0);
        check("rst_rdata", {core_rdata, dma_rdata, core_error, dma_error}, 66'd0);
        @(posedge clock); #1;
        reset = 0;

        // Zero-wait core load returning DEADBEEF.
        rd_val = 32'hDEADBEEF ^ 32'h0000_0100;
        txn(0, 0, SIZE_WORD, 32'h100, 32'h0, 0, 0);
        check("core_rdata_value", core_rdata, 32'hDEADBEEF);

        // Illegal DMA accesses; core result must stay untouched.
        txn(1, 1, SIZE_WORD, 32'h102, 32'h1111_2222, 0, 1);
        txn(1, 0, SIZE_HALF, 32'h101, 32'h0, 0, 1);
        txn(1, 0, 2'b10,     32'h100, 32'h0, 0, 1);
        check("core_rdata_kept", {core_rdata, core_error}, {32'hDEADBEEF, 1'b0});

        // Legal DMA half load with one wait state.
        rd_val = 32'hCAFE_0000;
        txn(1, 0, SIZE_HALF, 32'h102, 32'h0, 1, 0);

        // Core byte store with five mem_valid cycles.
        txn(0, 1, SIZE_BYTE, 32'h203, 32'h55, 4, 0);

        // Timeout: memory never responds.
        txn(0, 0, SIZE_WORD, 32'h180, 32'h0, -1, 0);

        // Contention: core x4, DMA, core x4, DMA.
        lat = 0;
        rd_val = 32'h1234_5678;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_grant_q.push_back('{write: 1'b0, size: SIZE_WORD, addr: 32'h1000, wdata: 32'h0});
                exp_resp_q.push_back('{dma: 1'b0, rdata: 32'h1234_5678 ^ 32'h1000, error: 1'b0});
            end
            exp_grant_q.push_back('{write: 1'b0, size: SIZE_WORD, addr: 32'h2000, wdata: 32'h0});
            exp_resp_q.push_back('{dma: 1'b1, rdata: 32'h1234_5678 ^ 32'h2000, error: 1'b0});
        end
        @(posedge clock); #1;
        core_req = 1; core_write = 0; core_size = SIZE_WORD; core_addr = 32'h1000;
        dma_req = 1;  dma_write = 0;  dma_size = SIZE_WORD;  dma_addr = 32'h2000;
        acks = 0;
        last_ack = -1;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            @(negedge clock);
            if (core_ack === 1'b1 || dma_ack === 1'b1) begin
                acks++;
                last_ack = c;
            end
        end
        check("contention_acks", acks, 10);
        check("contention_last_ack", last_ack, 29);
        $display("txn contention acks=%0d last_ack_cycle=%0d", acks, last_ack);
        @(posedge clock); #1;
        core_req = 0;
        dma_req = 0;

        // Reset in cycle 3 of a stalled transfer.
        lat = -1;
        exp_grant_q.push_back('{write: 1'b0, size: SIZE_WORD, addr: 32'h300, wdata: 32'h0});
        @(posedge clock); #1;
        core_req = 1; core_write = 0; core_size = SIZE_WORD; core_addr = 32'h300;
        repeat (3) @(posedge clock);
        #1;
        reset = 1;
        core_req = 0;
        @(negedge clock);
        check("pre_rst_valid", mem_valid, 1'b1);
        @(negedge clock);
        check("midrst_mem_valid", mem_valid, 1'b0);
        check("midrst_acks", {core_ack, dma_ack}, 2'b00);
        check("midrst_fields", {mem_addr, core_rdata, dma_rdata}, 96'd0);
        $display("txn reset during busy mem_valid=%0d", mem_valid);
        @(posedge clock); #1;
        reset = 0;
        rd_val = 32'h0F0F_0000;
        txn(0, 0, SIZE_WORD, 32'h400, 32'h0, 0, 0);

        repeat (3) @(negedge clock);
        check("resp_q_empty", exp_resp_q.size(), 0);
        check("grant_q_empty", exp_grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
